// File: rtl/shake256_squeeze_ctrl.sv
// SHAKE256 squeeze sequencer: captures rate blocks from the Keccak core and
// slices the byte stream into 128-bit big-endian words over valid/ready.
module shake256_squeeze_ctrl #(
  parameter int RATE_BYTES = 136,
  parameter int LEN_W      = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [LEN_W-1:0]        i_out_len,
  input  logic                    i_state_valid,
  input  logic [8*RATE_BYTES-1:0] i_state_in,
  output logic                    o_perm_start,
  output logic [127:0]            o_dout,
  output logic                    o_dout_valid,
  input  logic                    i_dout_ready,
  output logic                    o_dout_last,
  output logic [4:0]              o_dout_bytes,
  output logic                    o_busy,
  output logic                    o_done
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT, S_HOLD} state_t;

  state_t                  r_state;
  logic [LEN_W-1:0]        r_rem;
  logic [7:0]              r_ptr;
  logic [8*RATE_BYTES-1:0] r_blk;
  logic [63:0]             r_carry;
  logic [3:0]              r_fc;

  logic [4:0]   w_n;
  logic [4:0]   w_need;
  logic [7:0]   w_avail;
  logic [127:0] w_sh;
  logic [127:0] w_stream;
  logic [127:0] w_word;

  // w_stream is little-endian in stream order: carried bytes first, then block bytes from ptr.
  always_comb begin
    w_n      = (r_rem >= LEN_W'(16)) ? 5'd16 : r_rem[4:0];
    w_need   = w_n - {1'b0, r_fc};
    w_avail  = 8'(RATE_BYTES) - r_ptr;
    w_sh     = 128'(r_blk >> {r_ptr, 3'b000});
    w_stream = (r_fc != 4'd0) ? {w_sh[63:0], r_carry} : w_sh;
    w_word   = '0;
    for (int j = 0; j < 16; j++)
      if (5'(j) < w_n) w_word[127-8*j -: 8] = w_stream[8*j +: 8];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_rem        <= '0;
      r_ptr        <= '0;
      r_blk        <= '0;
      r_carry      <= '0;
      r_fc         <= '0;
      o_perm_start <= 1'b0;
      o_dout       <= '0;
      o_dout_valid <= 1'b0;
      o_dout_last  <= 1'b0;
      o_dout_bytes <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_perm_start <= 1'b0;
      o_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_out_len == '0) begin
              o_done <= 1'b1;
            end else begin
              r_rem   <= i_out_len;
              r_fc    <= '0;
              o_busy  <= 1'b1;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (i_state_valid) begin
            r_blk   <= i_state_in;
            r_ptr   <= '0;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if ({3'b000, w_need} <= w_avail) begin
            o_dout       <= w_word;
            o_dout_bytes <= w_n;
            o_dout_last  <= (r_rem == LEN_W'(w_n));
            o_dout_valid <= 1'b1;
            r_ptr        <= r_ptr + {3'b000, w_need};
            r_rem        <= r_rem - LEN_W'(w_n);
            r_fc         <= '0;
            r_state      <= S_HOLD;
          end else begin
            // Block runs dry mid-word: stash the tail (0 or 8 bytes) and fetch the next block.
            r_carry      <= w_sh[63:0];
            r_fc         <= w_avail[3:0];
            r_ptr        <= 8'(RATE_BYTES);
            o_perm_start <= 1'b1;
            r_state      <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (i_dout_ready) begin
            o_dout_valid <= 1'b0;
            if (r_rem == '0) begin
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_EMIT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shake256_squeeze_ctrl.sv
// Directed bench for shake256_squeeze_ctrl with a tiny stream model for expected words.
module tb_shake256_squeeze_ctrl;

  logic          clk = 1'b0;
  logic          rst_n, start, state_valid, dout_ready;
  logic [15:0]   out_len;
  logic [1087:0] state_in;
  logic          perm_start, dout_valid, dout_last, busy, done;
  logic [127:0]  dout;
  logic [4:0]    dout_bytes;

  int total = 0, bad = 0, cyc = 0;
  logic [127:0] got_w [0:31];
  logic [4:0]   got_b [0:31];
  logic         got_l [0:31];
  int nw, nperm, perm_nw, done_cyc, hs_cyc, bidx, feed;
  logic done_busy;
  logic [127:0] sv_w;
  logic [4:0]   sv_b;
  logic         sv_l;

  always #5 clk = ~clk;

  shake256_squeeze_ctrl #(.RATE_BYTES(136), .LEN_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_out_len(out_len),
    .i_state_valid(state_valid), .i_state_in(state_in), .o_perm_start(perm_start),
    .o_dout(dout), .o_dout_valid(dout_valid), .i_dout_ready(dout_ready),
    .o_dout_last(dout_last), .o_dout_bytes(dout_bytes), .o_busy(busy), .o_done(done));

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1087:0] mkblk(input int b);
    logic [1087:0] v;
    for (int k = 0; k < 136; k++) v[8*k +: 8] = 8'(b*128 + k);
    return v;
  endfunction

  // Stream byte s: block0 byte s, then block1 byte (s-136) = 0x80+(s-136).
  function automatic logic [127:0] exp_word(input int i, input int len);
    logic [127:0] w;
    int s;
    w = '0;
    for (int j = 0; j < 16; j++) begin
      s = 16*i + j;
      if (s < len) w[127-8*j -: 8] = (s < 136) ? 8'(s) : 8'(128 + s - 136);
    end
    return w;
  endfunction

  task automatic run(input int len);
    nw = 0; nperm = 0; perm_nw = -1; done_cyc = -1; hs_cyc = -1; bidx = 0;
    done_busy = 1'b1;
    dout_ready = 1'b1;
    out_len = 16'(len); start = 1'b1;
    tick();
    start = 1'b0;
    feed = 2;
    for (int c = 0; c < 600; c++) begin
      if (done) begin
        done_cyc = cyc; done_busy = busy;
        break;
      end
      state_valid = 1'b0;
      if (feed > 0) begin
        feed--;
        if (feed == 0) begin
          state_valid = 1'b1; state_in = mkblk(bidx); bidx++;
        end
      end
      if (perm_start) begin nperm++; perm_nw = nw; feed = 2; end
      if (dout_valid && dout_ready && nw < 32) begin
        got_w[nw] = dout; got_b[nw] = dout_bytes; got_l[nw] = dout_last;
        nw++; hs_cyc = cyc;
      end
      tick();
    end
    state_valid = 1'b0;
  endtask

  task automatic check_run(input string nm, input int len, input int exp_nw, input int exp_perm);
    int n;
    chk({nm, "_done_seen"}, 128'(done_cyc >= 0), 128'(1));
    chk({nm, "_nwords"}, 128'(nw), 128'(exp_nw));
    chk({nm, "_nperm"}, 128'(nperm), 128'(exp_perm));
    chk({nm, "_done_lag"}, 128'(done_cyc - hs_cyc), 128'(1));
    chk({nm, "_busy_at_done"}, 128'(done_busy), 128'(0));
    for (int i = 0; i < nw && i < exp_nw; i++) begin
      n = (len - 16*i > 16) ? 16 : len - 16*i;
      chk($sformatf("%s_word%0d", nm, i), got_w[i], exp_word(i, len));
      chk($sformatf("%s_bytes%0d", nm, i), 128'(got_b[i]), 128'(n));
      chk($sformatf("%s_last%0d", nm, i), 128'(got_l[i]), 128'(i == exp_nw-1));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; state_valid = 1'b0; dout_ready = 1'b0;
    out_len = '0; state_in = '0;
    tick(); tick();
    chk("reset_outs", {dout, 5'(0)} | 133'({dout_valid, dout_last, dout_bytes, perm_start, busy, done}), '0);
    rst_n = 1'b1;
    tick();

    // 32-byte digest
    run(32);
    check_run("len32", 32, 2, 0);
    chk("len32_w0_lit", got_w[0], 128'h000102030405060708090a0b0c0d0e0f);
    chk("len32_w1_lit", got_w[1], 128'h101112131415161718191a1b1c1d1e1f);

    // partial final word
    run(20);
    check_run("len20", 20, 2, 0);
    chk("len20_w1_lit", got_w[1], 128'h10111213000000000000000000000000);

    // straddle into second block
    run(160);
    check_run("len160", 160, 10, 1);
    chk("len160_perm_after_w7", 128'(perm_nw), 128'(8));
    chk("len160_w8_lit", got_w[8], 128'h80818283848586878081828384858687);
    chk("len160_w9_lit", got_w[9], 128'h88898a8b8c8d8e8f9091929394959697);

    // exact two-block boundary
    run(272);
    check_run("len272", 272, 17, 1);
    chk("len272_perm_after_w7", 128'(perm_nw), 128'(8));

    // zero-length request
    out_len = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", 128'(done), 128'(1));
    chk("zero_quiet", 128'({busy, perm_start, dout_valid}), 128'(0));
    tick();
    chk("zero_done_pulse", 128'(done), 128'(0));
    chk("zero_idle", 128'({busy, perm_start, dout_valid}), 128'(0));

    // backpressure then mid-stream reset
    dout_ready = 1'b0;
    out_len = 16'd32; start = 1'b1;
    tick();
    start = 1'b0;
    chk("bp_busy", 128'(busy), 128'(1));
    state_in = mkblk(0); state_valid = 1'b1;
    tick();
    state_valid = 1'b0;
    chk("bp_emit_not_valid", 128'(dout_valid), 128'(0));
    tick();
    chk("bp_valid", 128'(dout_valid), 128'(1));
    sv_w = dout; sv_b = dout_bytes; sv_l = dout_last;
    chk("bp_word", sv_w, 128'h000102030405060708090a0b0c0d0e0f);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_stable%0d", i), {dout, 1'(dout_valid), sv_b, sv_l},
          {sv_w, 1'b1, dout_bytes, dout_last});
      chk($sformatf("bp_ctl%0d", i), 128'({dout_bytes, dout_last}), 128'({5'd16, 1'b0}));
    end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("bp_after_hs", 128'(dout_valid), 128'(0));
    tick();
    chk("bp_next_valid", 128'(dout_valid), 128'(1));
    chk("bp_next_word", dout, 128'h101112131415161718191a1b1c1d1e1f);
    rst_n = 1'b0;
    tick();
    chk("midrst_outs", {dout, 5'(0)} | 133'({dout_valid, dout_last, dout_bytes, perm_start, busy, done}), '0);
    rst_n = 1'b1;
    tick();
    run(16);
    check_run("post_rst16", 16, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shake256_squeeze_ctrl.md
# shake256_squeeze_ctrl

Sequences the SHAKE256 squeeze phase. It captures each 1088-bit rate block from the Keccak permutation core and requests further permutations when a block runs out. It slices the contiguous squeezed byte stream into 128-bit big-endian digest words (first stream byte in bits [127:120]) and delivers them over a valid/ready handshake. It sits between the permutation core and the digest output/host interface, and handles arbitrary output lengths, including words that straddle two rate blocks.

## Interface
- RATE_BYTES, 136, SHAKE256 rate in bytes (fixed; other values unsupported)
- LEN_W, 16, width of requested output length in bytes
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin squeezing; sampled only in IDLE
- out_len  in  LEN_W  requested output bytes, latched on start
- state_valid  in  1  one-cycle pulse from core: state_in holds a fresh squeezed state; honoured only in WAIT
- state_in  in  1088  rate part of Keccak state; stream byte k = state_in[8k+7:8k]
- perm_start  out  1  one-cycle pulse requesting one Keccak-f permutation
- dout  out  128  digest word, big-endian byte order
- dout_valid  out  1  dout valid
- dout_ready  in  1  consumer accepts dout when dout_valid & dout_ready
- dout_last  out  1  current word is the final word
- dout_bytes  out  5  valid bytes in dout (1..16), left-justified in the MSBs
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last word is accepted, or after a zero-length request

## Operation
- Registers: rem (LEN_W bits, bytes still to emit), ptr (8 bits, byte offset in captured block, 0..136), blk (1088 bits), carry (64 bits), fc (fill count, 0 or 8).
- IDLE:
  - start & out_len==0: pulse done next cycle, stay IDLE.
  - start & out_len!=0: rem<=out_len, fc<=0, go to WAIT.
- WAIT: on state_valid, blk<=state_in, ptr<=0, go to EMIT. The first block arrives from the core unprompted; no perm_start is issued for it.
- EMIT: compute n=min(16,rem), need=n-fc, avail=136-ptr.
  - avail>=need: form the word from the fc carry bytes followed by need block bytes from ptr. Stream order is MSB-first. Zero-fill the low 16-n bytes. Set dout_bytes=n and dout_last=(rem==n). ptr+=need, rem-=n, fc<=0. Assert dout_valid and go to HOLD.
  - avail<need, only when avail is 8 or 0: carry<=the avail remaining bytes, fc<=avail, ptr<=136. Pulse perm_start and go to WAIT.
- HOLD: dout, dout_bytes and dout_last stay stable while dout_valid=1. On handshake, dout_valid<=0, then:
  - rem==0: pulse done, go to IDLE.
  - otherwise: go to EMIT.
- Because 136 is not a multiple of 16, block alignment alternates:
  - Even blocks: words at ptr 0,16,…,112, then 8 bytes are carried.
  - Odd blocks: first word completes the carry, then words at ptr 8,24,…,120.
- No permutation is requested once rem==0, even if the block is exhausted exactly.
- start while busy is ignored. state_valid outside WAIT is ignored. out_len is not re-sampled mid-operation.
- Arithmetic is unsigned; rem never underflows because n<=rem.

## Timing
- Reset (rst_n low at an edge): state IDLE. All outputs 0: dout, dout_valid, dout_last, dout_bytes, perm_start, busy, done. rem, ptr, fc and carry also clear. This applies mid-stream too; any in-flight word is discarded.
- All outputs are registered.
- start at edge t: busy=1 from cycle t+1.
- state_valid sampled at edge t: EMIT in cycle t+1, dout_valid=1 from cycle t+2.
- Carry path: EMIT in cycle c, perm_start=1 for cycle c+1 only, WAIT from cycle c+1.
- Handshake at edge h: dout_valid=0 in cycle h+1 (EMIT).
  - Next word valid at h+2 if it needs no permutation.
  - Peak throughput is one word per 2 cycles.
- Last handshake at edge h: done=1 in cycle h+1, busy=0 in cycle h+1.
- Zero-length start at edge t: done=1 in cycle t+1, and busy stays 0.

## Test plan
- Basic 32-byte digest: out_len=32, state bytes k=0x00..0x87.
  - Words 0x000102…0F and 0x101112…1F; dout_last on the second word only; dout_bytes=16 on both.
  - done one cycle after the second handshake; perm_start never asserted.
- Partial final word: out_len=20, same state.
  - Second word 0x10111213 followed by 96 zero bits; dout_bytes=4; dout_last=1.
- Block straddle: out_len=160, block0 bytes k, block1 bytes 0x80+k.
  - Exactly one perm_start, asserted after word 7 is accepted.
  - Word 8 = 0x8081…87 followed by 0x8081…87 (block0 bytes 128..135, then block1 bytes 0..7).
  - Word 9 = 0x88…97; 10 words total.
- Exact block boundary: out_len=272.
  - 17 words; one perm_start; no perm_start after the final word; last word dout_bytes=16.
- Zero length: out_len=0.
  - done pulse at t+1; busy, perm_start and dout_valid stay 0.
- Backpressure and reset:
  - dout_ready held low for 5 cycles: dout, dout_bytes and dout_last stay stable.
  - rst_n low for 1 cycle mid-stream: all outputs 0 at the next cycle; a fresh start with out_len=16 then produces one correct word.
